// File: rtl/eth_tlp_pkg.sv
// Word format shared by both sides of the TLP tap FIFO, plus the TX frame-state encoding.
package eth_tlp_pkg;
  localparam int TLPFIFO_W = 74;
  localparam int KEEP_LSB  = 66;
  localparam int DATA_LSB  = 2;
  localparam int LAST_BIT  = 1;
  localparam int USER_BIT  = 0;

  typedef struct packed {
    logic [7:0]  keep;
    logic [63:0] data;
    logic        last;
    logic        user;
  } tlpfifo_word_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_t;
endpackage

// File: rtl/eth_tlptx_obuf.sv
// Small synchronous DEPTH x W buffer with occupancy; head visible combinationally on rd_dat.
// Writer must never push into a full buffer unless it pops in the same cycle.
module eth_tlptx_obuf #(
  parameter int DEPTH = 4,
  parameter int W     = 74,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wr_dat,
  input  logic          pop,
  output logic [W-1:0]  rd_dat,
  output logic [AW:0]   occ
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign rd_dat = mem[rd_ptr];
endmodule

// File: rtl/eth_tlptx.sv
// Replays the TLP tap FIFO as a 64-bit AXI-Stream master; READ_LATENCY+1 cycles from non-empty to tvalid.
// Reads are credit-limited so occupancy plus in-flight reads never exceed OBUF_DEPTH while tready is low.
module eth_tlptx
  import eth_tlp_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int OBUF_DEPTH   = 4,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 rd_en,
  input  logic [TLPFIFO_W-1:0] dout,
  input  logic                 empty,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic [7:0]           m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     underrun_cnt
);
  localparam int OW = $clog2(OBUF_DEPTH);

  logic [READ_LATENCY-1:0] vpipe;
  logic [OW:0]             occ;
  logic [OW:0]             inflight;
  logic [OW+1:0]           credit_used;
  logic                    pop;
  tlpfifo_word_t           head;
  frame_state_t            state, state_nxt;

  assign pop = m_axis_tvalid && m_axis_tready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + {{OW{1'b0}}, vpipe[i]};
    end
  end

  // A pop this cycle frees a slot in time for a read issued now.
  assign credit_used = {1'b0, occ} + {1'b0, inflight} - {{(OW+1){1'b0}}, pop};
  assign rd_en       = rst_n && !empty && (credit_used < (OW+2)'(OBUF_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= rd_en;
      for (int i = 1; i < READ_LATENCY; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  eth_tlptx_obuf #(
    .DEPTH (OBUF_DEPTH),
    .W     (TLPFIFO_W)
  ) u_obuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (vpipe[READ_LATENCY-1]),
    .wr_dat (dout),
    .pop    (pop),
    .rd_dat (head),
    .occ    (occ)
  );

  // Stale buffer contents are masked so an idle stream shows all-zero fields.
  assign m_axis_tvalid = (occ != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? head.keep : '0;
  assign m_axis_tlast  = m_axis_tvalid && head.last;
  assign m_axis_tuser  = m_axis_tvalid && head.user;

  always_comb begin
    state_nxt = state;
    if (pop) state_nxt = head.last ? ST_IDLE : ST_IN_PKT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pkt_cnt      <= '0;
      err_cnt      <= '0;
      underrun_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop && head.last)              pkt_cnt      <= pkt_cnt + CNT_W'(1);
      if (pop && head.last && head.user) err_cnt      <= err_cnt + CNT_W'(1);
      if (state == ST_IN_PKT && occ == '0) underrun_cnt <= underrun_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_eth_tlptx.sv
// Directed bench for eth_tlptx: FIFO model with read latency, in-order scoreboard and counter model.
`timescale 1ns/1ps
module tb_eth_tlptx;
  localparam int RL = 2;
  localparam int OD = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rd_en;
  logic [73:0]   dout = '0;
  logic          empty = 1'b1;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic [CW-1:0] pkt_cnt, err_cnt, underrun_cnt;

  eth_tlptx #(.READ_LATENCY(RL), .OBUF_DEPTH(OD), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_en         (rd_en),
    .dout          (dout),
    .empty         (empty),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .pkt_cnt       (pkt_cnt),
    .err_cnt       (err_cnt),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [73:0]   fq[$];
  logic [73:0]   sb_q[$];
  logic [RL-1:0] dv = '0;
  logic [73:0]   dw [RL];
  logic          prev_rd = 1'b0;
  logic [73:0]   prev_word = '0;
  int            m_occ = 0;
  logic          m_in_pkt = 1'b0;
  logic [CW-1:0] m_pkt = '0, m_err = '0, m_und = '0;
  int            rd_count = 0, acc_count = 0;
  logic          stalled = 1'b0;
  logic [73:0]   held = '0, last_pop = '0;
  int            step_no = 0, first_tv = -1;
  int            rd_run = 0, rd_run_max = 0, tv_run = 0, tv_run_max = 0;

  task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_word(input logic [7:0] keep, input logic [63:0] data,
                           input logic last, input logic user);
    fq.push_back({keep, data, last, user});
    sb_q.push_back({keep, data, last, user});
  endtask

  task automatic push_frame(input int beats);
    for (int b = 0; b < beats; b++)
      push_word(8'hFF, {$urandom(), $urandom()}, logic'(b == beats - 1), 1'b0);
  endtask

  // 8 frames of 8 beats; frame 2 closes with tuser set
  task automatic push_stream();
    for (int f = 0; f < 8; f++)
      for (int b = 0; b < 8; b++)
        push_word(8'hFF, {$urandom(), $urandom()}, logic'(b == 7), logic'(f == 2 && b == 7));
  endtask

  task automatic step(input logic rdy, input logic fe);
    logic [73:0] obs, e;
    logic        popd;
    @(negedge clk);
    step_no++;
    for (int i = RL - 1; i > 0; i--) begin
      dv[i] = dv[i-1];
      dw[i] = dw[i-1];
    end
    dv[0] = prev_rd;
    dw[0] = prev_word;
    dout  = dv[RL-1] ? dw[RL-1] : 74'({$urandom(), $urandom(), $urandom()});
    m_axis_tready = rdy;
    empty = fe || (fq.size() == 0);
    #1;
    obs  = {m_axis_tkeep, m_axis_tdata, m_axis_tlast, m_axis_tuser};
    popd = m_axis_tvalid && m_axis_tready;
    chk("tvalid", 74'(m_axis_tvalid), 74'(m_occ != 0));
    if (stalled) chk("stall_hold", obs, held);
    if (m_in_pkt && m_occ == 0) m_und++;
    if (popd) begin
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL extra_beat: observed=%0h expected=none", obs);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("beat", obs, e);
        if (e[1]) begin
          m_pkt++;
          if (e[0]) m_err++;
          m_in_pkt = 1'b0;
        end else begin
          m_in_pkt = 1'b1;
        end
      end
      acc_count++;
      last_pop = obs;
    end
    prev_rd = 1'b0;
    if (rd_en) begin
      chk("rd_en_vs_empty", 74'(empty), 74'(0));
      chk("credit_le_depth", 74'((m_occ + $countones(dv) + 1 - int'(popd)) <= OD), 74'(1));
      if (fq.size() != 0) begin
        prev_word = fq.pop_front();
        prev_rd   = 1'b1;
        rd_count++;
      end
    end
    m_occ = m_occ + int'(dv[RL-1]) - int'(popd);
    rd_run = rd_en ? rd_run + 1 : 0;
    if (rd_run > rd_run_max) rd_run_max = rd_run;
    tv_run = m_axis_tvalid ? tv_run + 1 : 0;
    if (tv_run > tv_run_max) tv_run_max = tv_run;
    if (first_tv < 0 && m_axis_tvalid) first_tv = step_no;
    stalled = m_axis_tvalid && !m_axis_tready;
    held    = obs;
  endtask

  task automatic drain(input int max_steps);
    int n = 0;
    while ((sb_q.size() != 0 || m_occ != 0 || dv != '0 || prev_rd) && n < max_steps) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("drain_done", 74'(sb_q.size()), 74'(0));
    repeat (3) step(1'b1, 1'b0);
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_pkt_model"}, 74'(pkt_cnt), 74'(m_pkt));
    chk({tag, "_err_model"}, 74'(err_cnt), 74'(m_err));
    chk({tag, "_und_model"}, 74'(underrun_cnt), 74'(m_und));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rd_en"}, 74'(rd_en), 74'(0));
    chk({tag, "_tvalid"}, 74'(m_axis_tvalid), 74'(0));
    chk({tag, "_fields"}, {m_axis_tkeep, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 74'(0));
    chk({tag, "_cnts"}, 74'({pkt_cnt, err_cnt, underrun_cnt}), 74'(0));
  endtask

  // Reset mid-stream: everything already read from the FIFO is lost, unread words stay.
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    dv      = '0;
    prev_rd = 1'b0;
    repeat (rd_count - acc_count) void'(sb_q.pop_front());
    rd_count = 0; acc_count = 0;
    m_occ = 0; m_in_pkt = 1'b0; stalled = 1'b0;
    m_pkt = '0; m_err = '0; m_und = '0;
    dout  = {8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b0};
    #1;
    check_zero_outputs("rst_mid");
  endtask

  logic [CW-1:0] und0;
  int            s0;

  initial begin
    for (int i = 0; i < RL; i++) dw[i] = '0;
    #1 rst_n = 1'b0;
    empty = 1'b0;
    #1;
    check_zero_outputs("rst_init");
    empty = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(1'b1, 1'b0);

    // 3-beat frame: latency and contiguity
    push_frame(3);
    first_tv = -1; tv_run_max = 0;
    s0 = step_no + 1;
    drain(40);
    chk("t1_latency", 74'(first_tv - s0), 74'(RL + 1));
    chk("t1_contig", 74'(tv_run_max), 74'(3));
    chk("t1_pkt", 74'(pkt_cnt), 74'(1));
    chk("t1_err", 74'(err_cnt), 74'(0));
    chk("t1_und", 74'(underrun_cnt), 74'(0));

    // 64 back-to-back beats with tready high
    push_stream();
    rd_run_max = 0; tv_run_max = 0;
    drain(120);
    chk("t2_rd_run", 74'(rd_run_max), 74'(64));
    chk("t2_tv_run", 74'(tv_run_max), 74'(64));
    chk("t2_pkt", 74'(pkt_cnt), 74'(9));
    check_counters("t2");

    // Same stream, tready toggling every cycle
    push_stream();
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) step(logic'(i % 2 == 0), 1'b0);
    drain(60);
    chk("t3_pkt", 74'(pkt_cnt), 74'(17));
    chk("t3_err", 74'(err_cnt), 74'(2));
    check_counters("t3");

    // Intra-frame gap: empty forced for 5 cycles after two reads
    und0 = m_und;
    push_frame(4);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1);
    drain(60);
    chk("t4_und_delta", 74'(underrun_cnt - und0), 74'(5));
    chk("t4_pkt", 74'(pkt_cnt), 74'(18));
    check_counters("t4");

    // Single-beat errored frame with partial keep
    push_word(8'h0F, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
    drain(40);
    repeat (5) step(1'b1, 1'b0);
    chk("t5_tkeep", 74'(last_pop[73:66]), 74'(8'h0F));
    chk("t5_tuser", 74'(last_pop[0]), 74'(1));
    chk("t5_pkt", 74'(pkt_cnt), 74'(19));
    chk("t5_err", 74'(err_cnt), 74'(3));
    chk("t5_und_idle", 74'(underrun_cnt - und0), 74'(5));
    check_counters("t5");

    // Reset with 3 buffered and 2 in flight, then recovery
    push_frame(8);
    repeat (5) step(1'b0, 1'b0);
    do_reset();
    push_frame(3);
    repeat (3) @(negedge clk);
    empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drain(60);
    chk("t6_pkt", 74'(pkt_cnt), 74'(2));
    chk("t6_err", 74'(err_cnt), 74'(0));
    chk("t6_und", 74'(underrun_cnt), 74'(0));
    check_counters("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_tlptx.md
Name: eth_tlptx

Overview:
- FIFO-to-AXI-Stream transmitter.
- Reads 74-bit words {tkeep, tdata, tlast, tuser} from a standard (non-FWFT) FIFO and replays them as a 64-bit AXI-Stream master toward the Ethernet MAC TX path.
- It is the read side of the TLP tap FIFO, whose write side packs Eth+IP+UDP+TLP beats.
- Absorbs FIFO read latency with a credit-controlled output buffer, and keeps packet, error and underrun statistics.

Parameters:
- READ_LATENCY, 1, cycles from rd_en high to dout valid (1..3).
- OBUF_DEPTH, 4, output buffer entries; power of 2, >= READ_LATENCY+1.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  out  1  FIFO read strobe.
- dout  in  74  FIFO read data: [73:66] tkeep, [65:2] tdata, [1] tlast, [0] tuser.
- empty  in  1  FIFO empty flag.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready from MAC.
- m_axis_tdata  out  64  beat data.
- m_axis_tkeep  out  8  byte enables.
- m_axis_tlast  out  1  end of frame.
- m_axis_tuser  out  1  frame error/abort marker, passed through.
- pkt_cnt  out  CNT_W  frames sent (tlast beats accepted).
- err_cnt  out  CNT_W  frames sent with tuser=1 on the tlast beat.
- underrun_cnt  out  CNT_W  cycles with an intra-frame gap.

Behaviour:
- Reset (async assert, sync release):
  - rd_en=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0.
  - All counters 0; buffer pointers 0; in-flight valid pipe cleared.
  - Frame state returns to IDLE.
  - dout returning after reset for reads issued before reset is ignored.
- Read issue (combinational rd_en):
  - pop = m_axis_tvalid && m_axis_tready.
  - rd_en = !empty && (occ + inflight - pop) < OBUF_DEPTH.
  - occ is buffered words; inflight is reads issued but not yet returned.
  - The buffer can never overflow.
  - With OBUF_DEPTH >= READ_LATENCY+1 and tready held high, throughput is 1 beat/cycle.
- Read return:
  - A READ_LATENCY-deep shift register of valid bits tracks rd_en.
  - When its tail is set, dout is written into the buffer in the same cycle.
  - A simultaneous write and pop on a full buffer is legal and preserves occupancy.
- Output:
  - m_axis_tvalid = (occ != 0); m_axis_* come from the buffer head.
  - Head data is held stable while tvalid && !tready.
  - Latency from FIFO non-empty (idle pipeline) to first tvalid: READ_LATENCY+1 cycles. The word is registered into the buffer, then presented.
  - tkeep/tuser are passed through unmodified; no reordering or dropping.
- Frame FSM (on accepted beats):
  - IDLE -> IN_PKT on a pop with tlast=0.
  - IN_PKT -> IDLE on a pop with tlast=1.
  - A pop with tlast=1 in IDLE (single-beat frame) stays in IDLE.
- Counters:
  - pkt_cnt += 1 on every pop with tlast=1.
  - err_cnt += 1 on a pop with tlast=1 && tuser=1.
  - underrun_cnt += 1 each cycle with state==IN_PKT && occ==0. MAC TX cannot tolerate such gaps; this counter exposes the problem and the block takes no corrective action.
  - All counters wrap modulo 2^CNT_W.
- Boundaries:
  - empty rising mid-frame: rd_en drops; tvalid falls once the buffer drains; underrun counted.
  - tready low for N cycles: at most OBUF_DEPTH words pending (occ+inflight); rd_en stays low until credit frees.
  - rst_n asserted mid-frame: the partial frame is lost; the FIFO keeps any unread words.

Decomposition:
- Package eth_tlp_pkg holds:
  - TLPFIFO_W=74 and the field offsets KEEP_LSB=66, DATA_LSB=2, LAST_BIT=1, USER_BIT=0.
  - typedef struct packed tlpfifo_word_t {keep[7:0], data[63:0], last, user}, shared with the write side.
- Sub-module eth_tlptx_obuf: synchronous OBUF_DEPTH x 74 FIFO with occ output, parameterised on depth.
- Credit logic, valid pipe, frame FSM and counters stay in the top level.

Test Plan:
- 3-beat frame in FIFO (tlast on beat 3, tuser=0), tready=1 -> first tvalid READ_LATENCY+1 cycles after empty falls; 3 contiguous beats; pkt_cnt=1, err_cnt=0, underrun_cnt=0.
- 64 back-to-back beats (8 frames of 8), tready=1 -> rd_en high 64 consecutive cycles; tvalid contiguous; pkt_cnt=8.
- Same stream with tready toggling 1/0 every cycle -> no loss or duplication (compare against scoreboard); occ+inflight never exceeds 4; data stable while stalled.
- Frame of 4 beats with empty forced high for 5 cycles after beat 2 -> underrun_cnt=5 (± pipeline fill, checked exactly against the model); frame completes intact.
- Single-beat frame, tlast=1, tuser=1, tkeep=8'h0F -> output tkeep=8'h0F, tuser=1; pkt_cnt=1, err_cnt=1; FSM stays IDLE.
- rst_n pulsed low while 2 reads are in flight and 3 words are buffered -> outputs and counters 0 immediately; no stale beats after release; next frame from FIFO delivered correctly.
